// File: rtl/ofs_fim_pcie_pkg.sv
// Shared PCIe subsystem types: TLP function routing, completion status and
// the MMIO read request record used by the completion generator.
package ofs_fim_pcie_pkg;

  localparam int PCIE_HDR_WIDTH = 128;

  localparam logic [7:0] FMTTYPE_MRD3 = 8'h00;
  localparam logic [7:0] FMTTYPE_MRD4 = 8'h20;
  localparam logic [7:0] FMTTYPE_CPL  = 8'h0A;
  localparam logic [7:0] FMTTYPE_CPLD = 8'h4A;

  typedef struct packed {
    logic [10:0] vfn;
    logic [2:0]  pfn;
    logic        vf_active;
  } t_tlp_func;

  typedef enum logic [2:0] {
    CPL_SC  = 3'b000,
    CPL_UR  = 3'b001,
    CPL_CRS = 3'b010,
    CPL_CA  = 3'b100
  } t_cpl_status;

  typedef struct packed {
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic [9:0]  length;
    logic [31:0] addr;
    t_tlp_func   func;
    logic        hdr_4dw;
  } t_mmio_rd_req;

  // Anything but SC is sent as a data-less Cpl with a one-DW byte count.
  function automatic logic [PCIE_HDR_WIDTH-1:0] func_build_cpl_hdr(
    input t_mmio_rd_req req,
    input t_cpl_status  status,
    input logic [7:0]   bus_num
  );
    logic [PCIE_HDR_WIDTH-1:0] h;
    h = '0;
    if (status == CPL_SC) begin
      h[127:120] = FMTTYPE_CPLD;
      h[105:96]  = req.length;
      h[75:64]   = {req.length, 2'b00};
    end else begin
      h[127:120] = FMTTYPE_CPL;
      h[105:96]  = 10'd0;
      h[75:64]   = 12'd4;
    end
    h[118:116] = req.tc;
    h[114]     = req.attr[2];
    h[109:108] = req.attr[1:0];
    h[95:80]   = {bus_num, 5'b00000, req.func.pfn};
    h[79:77]   = status;
    h[76]      = 1'b0;
    h[63:48]   = req.req_id;
    h[47:40]   = req.tag;
    h[38:32]   = {req.addr[6:2], 2'b00};
    return h;
  endfunction

endpackage

// File: rtl/ofs_fim_pcie_cpl_hdr_build.sv
// Combinational completion header assembly from a captured MMIO read request.
module ofs_fim_pcie_cpl_hdr_build
  import ofs_fim_pcie_pkg::*;
(
  input  t_mmio_rd_req                req,
  input  t_cpl_status                 status,
  input  logic [7:0]                  cfg_bus_num,
  output logic [PCIE_HDR_WIDTH-1:0]   cpl_hdr
);

  assign cpl_hdr = func_build_cpl_hdr(req, status, cfg_bus_num);

endmodule

// File: rtl/ofs_fim_pcie_mmio_rd_cpl_gen.sv
// Host MMIO read responder: issues one CSR read per request and returns a
// single-beat CplD, a UR Cpl for unsupported requests, or all-ones on timeout.
module ofs_fim_pcie_mmio_rd_cpl_gen
  import ofs_fim_pcie_pkg::*;
#(
  parameter int CSR_TIMEOUT = 512,
  parameter int CSR_AW      = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [PCIE_HDR_WIDTH-1:0]  req_hdr,
  input  t_tlp_func                  req_func,
  input  logic [7:0]                 cfg_bus_num,
  output logic                       csr_rd_valid,
  output logic [CSR_AW-1:0]          csr_rd_addr,
  output t_tlp_func                  csr_rd_func,
  input  logic                       csr_rd_rsp_valid,
  input  logic [63:0]                csr_rd_rsp_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       tx_sop,
  output logic                       tx_eop,
  output logic [PCIE_HDR_WIDTH-1:0]  tx_hdr,
  output logic [255:0]               tx_data,
  output logic                       tx_vf_active,
  output logic                       err_csr_timeout,
  output logic                       err_unsupported
);

  localparam int CNT_W = $clog2(CSR_TIMEOUT);

  typedef enum logic [1:0] {IDLE, CSR_REQ, CSR_WAIT, TX_CPL} t_state;

  t_state        state;
  t_mmio_rd_req  req_q;
  t_cpl_status   status_q;
  logic [CNT_W-1:0] cnt;
  t_mmio_rd_req  req_in;
  logic          in_supported;

  always_comb begin
    req_in         = '0;
    req_in.hdr_4dw = req_hdr[125];
    req_in.tc      = req_hdr[118:116];
    req_in.attr    = {req_hdr[114], req_hdr[109:108]};
    req_in.length  = req_hdr[105:96];
    req_in.req_id  = req_hdr[95:80];
    req_in.tag     = req_hdr[79:72];
    req_in.addr    = req_hdr[125] ? req_hdr[31:0] : req_hdr[63:32];
    req_in.func    = req_func;
    in_supported   = (req_hdr[127:120] == FMTTYPE_MRD3 || req_hdr[127:120] == FMTTYPE_MRD4)
                  && (req_hdr[105:96] == 10'd1 || req_hdr[105:96] == 10'd2);
  end

  // A single-DW read returns whichever half of the 8B CSR word the address selects.
  function automatic logic [255:0] place_data(input logic [63:0] d, input t_mmio_rd_req r);
    logic [255:0] p;
    p = '0;
    if (r.length == 10'd2) p[63:0] = d;
    else                   p[31:0] = r.addr[2] ? d[63:32] : d[31:0];
    return p;
  endfunction

  assign csr_rd_addr  = {req_q.addr[CSR_AW-1:3], 3'b000};
  assign csr_rd_func  = req_q.func;
  assign tx_vf_active = req_q.func.vf_active;

  ofs_fim_pcie_cpl_hdr_build u_hdr_build (
    .req         (req_q),
    .status      (status_q),
    .cfg_bus_num (cfg_bus_num),
    .cpl_hdr     (tx_hdr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      req_ready       <= 1'b0;
      csr_rd_valid    <= 1'b0;
      tx_valid        <= 1'b0;
      tx_sop          <= 1'b0;
      tx_eop          <= 1'b0;
      err_csr_timeout <= 1'b0;
      err_unsupported <= 1'b0;
      cnt             <= '0;
    end else begin
      csr_rd_valid    <= 1'b0;
      err_csr_timeout <= 1'b0;
      err_unsupported <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            req_q     <= req_in;
            if (in_supported) begin
              status_q     <= CPL_SC;
              csr_rd_valid <= 1'b1;
              state        <= CSR_REQ;
            end else begin
              status_q        <= CPL_UR;
              tx_data         <= '0;
              tx_valid        <= 1'b1;
              tx_sop          <= 1'b1;
              tx_eop          <= 1'b1;
              err_unsupported <= 1'b1;
              state           <= TX_CPL;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        CSR_REQ: begin
          cnt   <= '0;
          state <= CSR_WAIT;
        end
        CSR_WAIT: begin
          cnt <= cnt + 1'b1;
          // The response is checked first so a coincident timeout is not flagged.
          if (csr_rd_rsp_valid) begin
            tx_data  <= place_data(csr_rd_rsp_data, req_q);
            tx_valid <= 1'b1;
            tx_sop   <= 1'b1;
            tx_eop   <= 1'b1;
            state    <= TX_CPL;
          end else if (cnt == CNT_W'(CSR_TIMEOUT - 1)) begin
            tx_data         <= place_data({64{1'b1}}, req_q);
            tx_valid        <= 1'b1;
            tx_sop          <= 1'b1;
            tx_eop          <= 1'b1;
            err_csr_timeout <= 1'b1;
            state           <= TX_CPL;
          end
        end
        TX_CPL: begin
          if (tx_ready) begin
            tx_valid  <= 1'b0;
            tx_sop    <= 1'b0;
            tx_eop    <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofs_fim_pcie_mmio_rd_cpl_gen.sv
// Randomized bench for the MMIO read completion generator; expected completions
// come from a field-level model of the request/completion TLP rules.
module tb_ofs_fim_pcie_mmio_rd_cpl_gen;
  import ofs_fim_pcie_pkg::*;

  localparam int TO = 16;
  localparam int AW = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_hdr;
  t_tlp_func    req_func;
  logic [7:0]   cfg_bus_num;
  logic         csr_rd_valid;
  logic [AW-1:0] csr_rd_addr;
  t_tlp_func    csr_rd_func;
  logic         csr_rd_rsp_valid;
  logic [63:0]  csr_rd_rsp_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_sop;
  logic         tx_eop;
  logic [127:0] tx_hdr;
  logic [255:0] tx_data;
  logic         tx_vf_active;
  logic         err_csr_timeout;
  logic         err_unsupported;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ofs_fim_pcie_mmio_rd_cpl_gen #(.CSR_TIMEOUT(TO), .CSR_AW(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_hdr          (req_hdr),
    .req_func         (req_func),
    .cfg_bus_num      (cfg_bus_num),
    .csr_rd_valid     (csr_rd_valid),
    .csr_rd_addr      (csr_rd_addr),
    .csr_rd_func      (csr_rd_func),
    .csr_rd_rsp_valid (csr_rd_rsp_valid),
    .csr_rd_rsp_data  (csr_rd_rsp_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .tx_sop           (tx_sop),
    .tx_eop           (tx_eop),
    .tx_hdr           (tx_hdr),
    .tx_data          (tx_data),
    .tx_vf_active     (tx_vf_active),
    .err_csr_timeout  (err_csr_timeout),
    .err_unsupported  (err_unsupported)
  );

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Sends one request, plays the CSR responder (rsp_delay cycles after the strobe,
  // -1 for never) and holds tx_ready low for ready_low cycles of tx_valid.
  task automatic applyStimulus(
    input logic [7:0]  ft,
    input logic [9:0]  len,
    input logic [31:0] addr,
    input logic [15:0] rid,
    input logic [7:0]  tag,
    input logic [2:0]  tc,
    input logic [2:0]  attr,
    input t_tlp_func   fn,
    input int          rsp_delay,
    input logic [63:0] rsp_data,
    input int          ready_low
  );
    logic [127:0] hdr;
    logic [31:0]  e_dw0, e_dw1, e_dw2;
    logic [63:0]  d;
    logic [255:0] e_data;
    logic [386:0] snap;
    logic [AW-1:0] got_addr;
    t_tlp_func    got_func;
    bit supp, timeout, hs, stable_ok, rdy_bad;
    int n, cyc, strobes, strobe_cyc, tx_cyc, n_to, n_ur, e_lat;

    supp    = (ft == 8'h00 || ft == 8'h20) && (len == 10'd1 || len == 10'd2);
    timeout = supp && !(rsp_delay >= 1 && rsp_delay <= TO);
    d       = timeout ? 64'hFFFF_FFFF_FFFF_FFFF : rsp_data;

    hdr = '0;
    hdr[127:96] = {ft, 1'b0, tc, 1'b0, attr[2], 4'b0000, attr[1:0], 2'b00, len};
    hdr[95:64]  = {rid, tag, 8'hFF};
    if (ft[5]) begin
      hdr[63:32] = $urandom;
      hdr[31:0]  = addr;
    end else begin
      hdr[63:32] = addr;
      hdr[31:0]  = $urandom;
    end

    e_dw0 = (32'(supp ? 8'h4A : 8'h0A) << 24) | (32'(tc) << 20) | (32'(attr[2]) << 18)
          | (32'(attr[1:0]) << 12) | (supp ? 32'(len) : 32'd0);
    e_dw1 = (32'(cfg_bus_num) << 24) | (32'(fn.pfn) << 16) | (supp ? 32'd0 : (32'd1 << 13))
          | (supp ? 32'(len) * 4 : 32'd4);
    e_dw2 = (32'(rid) << 16) | (32'(tag) << 8) | (addr & 32'h7C);
    if (!supp)            e_data = '0;
    else if (len == 10'd2) e_data = 256'(d);
    else                   e_data = 256'((d >> (addr[2] ? 32 : 0)) & 64'hFFFF_FFFF);
    e_lat = !supp ? 1 : (timeout ? TO + 1 : rsp_delay + 1);

    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_hdr   = hdr;
    req_func  = fn;
    @(negedge clk);
    req_valid = 1'b0;
    req_hdr   = {$urandom, $urandom, $urandom, $urandom};

    cyc = 1; strobes = 0; strobe_cyc = -1; tx_cyc = -1; n_to = 0; n_ur = 0;
    hs = 0; stable_ok = 1; rdy_bad = 0; snap = '0; got_addr = '0; got_func = '0;
    while (!hs && cyc < TO + 40) begin
      csr_rd_rsp_valid = 1'b0;
      if (csr_rd_valid) begin
        strobes++;
        strobe_cyc = cyc;
        got_addr   = csr_rd_addr;
        got_func   = csr_rd_func;
      end
      if (err_csr_timeout) n_to++;
      if (err_unsupported) n_ur++;
      if (req_ready) rdy_bad = 1;
      if (strobe_cyc >= 0 && rsp_delay >= 0 && cyc == strobe_cyc + rsp_delay) begin
        csr_rd_rsp_valid = 1'b1;
        csr_rd_rsp_data  = rsp_data;
      end
      if (tx_valid) begin
        if (tx_cyc < 0) begin
          tx_cyc = cyc;
          snap   = {tx_hdr, tx_data, tx_sop, tx_eop, tx_vf_active};
        end else if ({tx_hdr, tx_data, tx_sop, tx_eop, tx_vf_active} !== snap) begin
          stable_ok = 0;
        end
        tx_ready = (cyc - tx_cyc >= ready_low);
        if (tx_ready) hs = 1;
      end else begin
        tx_ready = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'b0;
    csr_rd_rsp_valid = 1'b0;

    checkOutput("handshake", hs, 1'b1);
    checkOutput("csr_strobes", strobes, supp ? 1 : 0);
    if (supp) begin
      checkOutput("csr_rd_addr", got_addr, (addr & 32'((1 << AW) - 1)) & ~32'h7);
      checkOutput("csr_rd_func", got_func, fn);
      checkOutput("latency", tx_cyc - strobe_cyc, e_lat);
    end else begin
      checkOutput("latency", tx_cyc, e_lat);
    end
    checkOutput("tx_hdr", snap[386:259], {e_dw0, e_dw1, e_dw2, 32'h0});
    checkOutput("tx_data", snap[258:3], e_data);
    checkOutput("sop_eop", snap[2:1], 2'b11);
    checkOutput("vf_active", snap[0], fn.vf_active);
    checkOutput("err_timeout_cnt", n_to, timeout ? 1 : 0);
    checkOutput("err_unsup_cnt", n_ur, supp ? 0 : 1);
    checkOutput("tx_stable", stable_ok, 1'b1);
    checkOutput("req_ready_busy", rdy_bad, 1'b0);
    checkOutput("tx_valid_drop", tx_valid, 1'b0);
    checkOutput("req_ready_back", req_ready, 1'b1);
  endtask

  task automatic applyResetMidOp();
    bit saw;
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_hdr   = '0;
    req_hdr[127:96] = 32'h0000_0001;
    req_hdr[63:32]  = 32'h0000_3000;
    req_func  = '0;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rst_pre_strobe", csr_rd_valid, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_tx_valid", tx_valid, 1'b0);
    checkOutput("rst_mid_req_ready", req_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_release_ready", req_ready, 1'b1);
    csr_rd_rsp_valid = 1'b1;
    csr_rd_rsp_data  = 64'h0123_4567_89AB_CDEF;
    saw = 0;
    repeat (TO + 6) begin
      @(negedge clk);
      csr_rd_rsp_valid = 1'b0;
      if (tx_valid || csr_rd_valid || err_csr_timeout || err_unsupported) saw = 1;
    end
    checkOutput("rst_quiet", saw, 1'b0);
  endtask

  initial begin
    logic [7:0] fts [6];
    logic [9:0] lens [6];
    logic [7:0] ft;
    logic [9:0] len;
    logic [31:0] addr;
    int dly;

    fts  = '{8'h00, 8'h20, 8'h00, 8'h20, 8'h40, 8'h60};
    lens = '{10'd1, 10'd2, 10'd1, 10'd2, 10'd4, 10'd0};
    rst = 1'b1; req_valid = 1'b0; req_hdr = '0; req_func = '0; cfg_bus_num = 8'h3C;
    csr_rd_rsp_valid = 1'b0; csr_rd_rsp_data = '0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", req_ready, 1'b0);
    checkOutput("rst_outputs", {csr_rd_valid, tx_valid, tx_sop, tx_eop, err_csr_timeout, err_unsupported}, 6'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("req_ready_after_rst", req_ready, 1'b1);

    applyStimulus(8'h00, 10'd2, 32'h0000_1000, 16'h0100, 8'h5A, 3'd0, 3'd0, '0, 3, 64'h1122_3344_5566_7788, 0);
    applyStimulus(8'h20, 10'd1, 32'h0000_2004, 16'h0200, 8'h11, 3'd2, 3'd5, t_tlp_func'({11'd3, 3'd2, 1'b1}), 2, 64'hAAAA_BBBB_CCCC_DDDD, 0);
    applyStimulus(8'h00, 10'd1, 32'h0000_0040, 16'h0300, 8'h22, 3'd0, 3'd0, '0, -1, 64'h0, 0);
    applyStimulus(8'h00, 10'd4, 32'h0000_0100, 16'h0400, 8'h33, 3'd1, 3'd2, '0, 2, 64'h5555, 0);
    applyStimulus(8'h40, 10'd1, 32'h0000_0104, 16'h0500, 8'h44, 3'd7, 3'd7, t_tlp_func'({11'd0, 3'd5, 1'b0}), 2, 64'h6666, 0);
    applyStimulus(8'h00, 10'd2, 32'h0000_0208, 16'h0600, 8'h55, 3'd0, 3'd0, '0, 1, 64'hDEAD_BEEF_CAFE_F00D, 10);
    applyStimulus(8'h20, 10'd1, 32'h0000_020C, 16'h0601, 8'h56, 3'd0, 3'd0, '0, 1, 64'h1357_9BDF_2468_ACE0, 0);
    applyStimulus(8'h00, 10'd2, 32'h0000_0300, 16'h0700, 8'h66, 3'd0, 3'd0, '0, TO, 64'h0F0F_0F0F_0F0F_0F0F, 0);
    applyStimulus(8'h00, 10'd2, 32'h0000_0310, 16'h0701, 8'h67, 3'd0, 3'd0, '0, 0, 64'h7777, 0);
    applyStimulus(8'h00, 10'd1, 32'h0000_0314, 16'h0702, 8'h68, 3'd0, 3'd0, '0, TO + 1, 64'h8888, 0);

    applyResetMidOp();
    applyStimulus(8'h00, 10'd1, 32'h0000_3004, 16'h0800, 8'h77, 3'd0, 3'd0, '0, 2, 64'h9999_0000_1111_2222, 0);

    for (int i = 0; i < 40; i++) begin
      ft   = fts[$urandom_range(0, 5)];
      len  = lens[$urandom_range(0, 5)];
      addr = $urandom & 32'hFFFF_FFFC;
      dly  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO + 2));
      cfg_bus_num = 8'($urandom);
      applyStimulus(ft, len, addr, 16'($urandom), 8'($urandom), 3'($urandom), 3'($urandom),
                    t_tlp_func'(15'($urandom)), dly, {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
